// File: rtl/alu_thread_sched_pkg.sv
// Shared types and constants for the per-thread ALU issue scheduler.
// Purely declarative: no logic, no latency, no flow control.
package alu_thread_sched_pkg;

  localparam int ADDR_LEN    = 32;
  localparam int NUM_THREADS = 4;
  localparam int TID_W       = $clog2(NUM_THREADS);
  localparam int PC_W        = ADDR_LEN - 2;

  localparam logic [PC_W-1:0] RESET_PC = '0;

  typedef logic [TID_W-1:0] thread_id_t;
  typedef logic [PC_W-1:0]  pc_t;

  typedef enum logic [1:0] {
    TS_IDLE,
    TS_READY,
    TS_WAIT_ALU,
    TS_WAIT_LSU
  } thread_state_t;

  function automatic logic state_is_busy(input thread_state_t s);
    return (s == TS_WAIT_ALU) || (s == TS_WAIT_LSU);
  endfunction

endpackage

// File: rtl/alu_thread_sched_rr_arbiter.sv
// Round-robin pick of the first set request at or above ptr_i, wrapping modulo N.
// Zero latency (purely combinational); no flow control, the caller gates the grant.
module alu_thread_sched_rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    elig_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic            grant_valid_o,
  output logic [ID_W-1:0] grant_id_o
);

  logic [ID_W-1:0] idx;

  // N is a power of two, so the ID_W-bit add wraps exactly at N.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_id_o    = '0;
    idx           = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr_i + ID_W'(k);
      if (!grant_valid_o && elig_i[idx]) begin
        grant_valid_o = 1'b1;
        grant_id_o    = idx;
      end
    end
  end

endmodule

// File: rtl/alu_thread_sched.sv
// Per-thread issue scheduler sharing one ALU: holds thread PCs/states, issues one ready thread per cycle round-robin.
// Issue is zero-latency from registered state; alu_stall suppresses issue while completions keep retiring.
module alu_thread_sched #(
  parameter int              NUM_THREADS = alu_thread_sched_pkg::NUM_THREADS,
  parameter int              TID_W       = alu_thread_sched_pkg::TID_W,
  parameter int              PC_W        = alu_thread_sched_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC    = alu_thread_sched_pkg::RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_THREADS-1:0] thread_en,
  input  logic [NUM_THREADS-1:0] inst_valid,
  input  logic [NUM_THREADS-1:0] inst_is_mem,
  input  logic                   alu_stall,
  output logic                   issue_valid,
  output logic [TID_W-1:0]       issue_tid,
  output logic [PC_W-1:0]        issue_pc,
  output logic [NUM_THREADS-1:0] inst_ack,
  input  logic                   alu_done_valid,
  input  logic [TID_W-1:0]       alu_done_tid,
  input  logic [PC_W-1:0]        alu_new_pc,
  input  logic                   lsu_done_valid,
  input  logic [TID_W-1:0]       lsu_done_tid,
  output logic [NUM_THREADS-1:0] thread_busy,
  output logic                   err
);

  import alu_thread_sched_pkg::*;

  thread_state_t          state_q [NUM_THREADS];
  thread_state_t          state_d [NUM_THREADS];
  logic [PC_W-1:0]        pc_q    [NUM_THREADS];
  logic [PC_W-1:0]        pc_d    [NUM_THREADS];
  logic [TID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                   err_q, err_d;

  logic [NUM_THREADS-1:0] eligible;
  logic [NUM_THREADS-1:0] granted;
  logic [NUM_THREADS-1:0] alu_hit;
  logic [NUM_THREADS-1:0] lsu_hit;
  logic                   grant_vld;
  logic [TID_W-1:0]       grant_id;

  always_comb begin
    eligible    = '0;
    alu_hit     = '0;
    lsu_hit     = '0;
    thread_busy = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      eligible[i]    = (state_q[i] == TS_READY) && inst_valid[i] && thread_en[i];
      alu_hit[i]     = alu_done_valid && (alu_done_tid == TID_W'(i));
      lsu_hit[i]     = lsu_done_valid && (lsu_done_tid == TID_W'(i));
      thread_busy[i] = state_is_busy(state_q[i]);
    end
  end

  alu_thread_sched_rr_arbiter #(
    .N    (NUM_THREADS),
    .ID_W (TID_W)
  ) u_rr_arbiter (
    .elig_i        (eligible),
    .ptr_i         (rr_ptr_q),
    .grant_valid_o (grant_vld),
    .grant_id_o    (grant_id)
  );

  assign issue_valid = grant_vld && !alu_stall;
  assign issue_tid   = grant_id;
  assign issue_pc    = pc_q[grant_id];

  always_comb begin
    granted = '0;
    if (issue_valid) granted[grant_id] = 1'b1;
  end

  assign inst_ack = granted;
  assign err      = err_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (issue_valid) rr_ptr_d = grant_id + TID_W'(1);
  end

  // Completions that don't match the thread's state are dropped but flagged.
  always_comb begin
    err_d = err_q;
    for (int i = 0; i < NUM_THREADS; i++) begin
      state_d[i] = state_q[i];
      pc_d[i]    = pc_q[i];
      case (state_q[i])
        TS_IDLE: begin
          if (thread_en[i]) state_d[i] = TS_READY;
          if (alu_hit[i] || lsu_hit[i]) err_d = 1'b1;
        end
        TS_READY: begin
          if (granted[i]) begin
            state_d[i] = inst_is_mem[i] ? TS_WAIT_LSU : TS_WAIT_ALU;
          end else if (!thread_en[i]) begin
            state_d[i] = TS_IDLE;
          end
          if (alu_hit[i] || lsu_hit[i]) err_d = 1'b1;
        end
        TS_WAIT_ALU: begin
          if (alu_hit[i]) begin
            pc_d[i]    = alu_new_pc;
            state_d[i] = thread_en[i] ? TS_READY : TS_IDLE;
          end
          if (lsu_hit[i]) err_d = 1'b1;
        end
        TS_WAIT_LSU: begin
          // The ALU leg only resolves the PC; the LSU leg releases the thread.
          if (alu_hit[i]) pc_d[i] = alu_new_pc;
          if (lsu_hit[i]) state_d[i] = thread_en[i] ? TS_READY : TS_IDLE;
        end
        default: state_d[i] = TS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        state_q[i] <= TS_IDLE;
        pc_q[i]    <= RESET_PC;
      end
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        state_q[i] <= state_d[i];
        pc_q[i]    <= pc_d[i];
      end
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_thread_sched.sv
// Table-driven bench for alu_thread_sched: per-cycle vectors with an issue scoreboard,
// plus a hand-written mid-cycle reset and late-completion sequence.
module tb_alu_thread_sched;

  import alu_thread_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  thread_en, inst_valid, inst_is_mem;
  logic        alu_stall;
  logic        issue_valid;
  logic [1:0]  issue_tid;
  logic [29:0] issue_pc;
  logic [3:0]  inst_ack;
  logic        alu_done_valid;
  logic [1:0]  alu_done_tid;
  logic [29:0] alu_new_pc;
  logic        lsu_done_valid;
  logic [1:0]  lsu_done_tid;
  logic [3:0]  thread_busy;
  logic        err;

  always #5 clk = ~clk;

  alu_thread_sched dut (
    .clk            (clk),
    .rst            (rst),
    .thread_en      (thread_en),
    .inst_valid     (inst_valid),
    .inst_is_mem    (inst_is_mem),
    .alu_stall      (alu_stall),
    .issue_valid    (issue_valid),
    .issue_tid      (issue_tid),
    .issue_pc       (issue_pc),
    .inst_ack       (inst_ack),
    .alu_done_valid (alu_done_valid),
    .alu_done_tid   (alu_done_tid),
    .alu_new_pc     (alu_new_pc),
    .lsu_done_valid (lsu_done_valid),
    .lsu_done_tid   (lsu_done_tid),
    .thread_busy    (thread_busy),
    .err            (err)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  en, iv, mem;
    logic        stall;
    logic        ad_v;
    logic [1:0]  ad_tid;
    logic [29:0] ad_pc;
    logic        ld_v;
    logic [1:0]  ld_tid;
    logic        x_iv;
    logic [1:0]  x_tid;
    logic [29:0] x_pc;
    logic [3:0]  x_busy;
    logic        x_err;
  } vec_t;

  typedef struct {
    logic [1:0]  tid;
    logic [29:0] pc;
  } iss_t;

  vec_t vecs[$];
  iss_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic r, input logic [3:0] en, iv, mem, input logic stall,
                     input logic ad_v, input logic [1:0] ad_tid, input logic [29:0] ad_pc,
                     input logic ld_v, input logic [1:0] ld_tid,
                     input logic x_iv, input logic [1:0] x_tid, input logic [29:0] x_pc,
                     input logic [3:0] x_busy, input logic x_err);
    vec_t v;
    v.rst = r; v.en = en; v.iv = iv; v.mem = mem; v.stall = stall;
    v.ad_v = ad_v; v.ad_tid = ad_tid; v.ad_pc = ad_pc; v.ld_v = ld_v; v.ld_tid = ld_tid;
    v.x_iv = x_iv; v.x_tid = x_tid; v.x_pc = x_pc; v.x_busy = x_busy; v.x_err = x_err;
    vecs.push_back(v);
  endtask

  task automatic expect_issue(input logic [1:0] tid, input logic [29:0] pc);
    iss_t e;
    e.tid = tid;
    e.pc  = pc;
    sb.push_back(e);
  endtask

  task automatic observe(input string tag, input logic x_iv, input logic [1:0] x_tid,
                         input logic [3:0] x_busy, input logic x_err);
    logic [3:0] x_ack;
    iss_t       e;
    x_ack = x_iv ? (4'b0001 << x_tid) : 4'b0000;
    chk({tag, ".issue_valid"}, 32'(issue_valid), 32'(x_iv));
    chk({tag, ".inst_ack"},    32'(inst_ack),    32'(x_ack));
    chk({tag, ".thread_busy"}, 32'(thread_busy), 32'(x_busy));
    chk({tag, ".err"},         32'(err),         32'(x_err));
    if (issue_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL %s.scoreboard: issue of tid %0d pc %0h with no expected entry",
                 tag, issue_tid, issue_pc);
      end else begin
        e = sb.pop_front();
        chk({tag, ".issue_tid"}, 32'(issue_tid), 32'(e.tid));
        chk({tag, ".issue_pc"},  32'(issue_pc),  32'(e.pc));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    thread_en = '0; inst_valid = '0; inst_is_mem = '0; alu_stall = 1'b0;
    alu_done_valid = 1'b0; alu_done_tid = '0; alu_new_pc = '0;
    lsu_done_valid = 1'b0; lsu_done_tid = '0;
    #1 rst = 1'b0;

    //  rst en     iv     mem    stl adv at  apc     ldv lt  xiv xt  xpc     xbusy  xerr
    // reset, then round-robin 0,1,2,3,0 with one-cycle completions
    add(0, 4'hF, 4'hF, 4'h0, 0, 0, 0, 30'h0,  0, 0, 0, 0, 30'h0,  4'h0, 0);
    add(1, 4'hF, 4'hF, 4'h0, 0, 0, 0, 30'h0,  0, 0, 0, 0, 30'h0,  4'h0, 0);
    add(1, 4'hF, 4'hF, 4'h0, 0, 0, 0, 30'h0,  0, 0, 1, 0, 30'h0,  4'h0, 0);
    add(1, 4'hF, 4'hF, 4'h0, 0, 1, 0, 30'h0,  0, 0, 1, 1, 30'h0,  4'h1, 0);
    add(1, 4'hF, 4'hF, 4'h0, 0, 1, 1, 30'h0,  0, 0, 1, 2, 30'h0,  4'h2, 0);
    add(1, 4'hF, 4'hF, 4'h0, 0, 1, 2, 30'h0,  0, 0, 1, 3, 30'h0,  4'h4, 0);
    add(1, 4'hF, 4'hF, 4'h0, 0, 1, 3, 30'h0,  0, 0, 1, 0, 30'h0,  4'h8, 0);
    add(1, 4'hF, 4'h0, 4'h0, 0, 1, 0, 30'h0,  0, 0, 0, 0, 30'h0,  4'h1, 0);
    // PC writeback, no grant in the completion cycle
    add(1, 4'hF, 4'h4, 4'h0, 0, 0, 0, 30'h0,  0, 0, 1, 2, 30'h0,  4'h0, 0);
    add(1, 4'hF, 4'h4, 4'h0, 0, 1, 2, 30'h40, 0, 0, 0, 0, 30'h0,  4'h4, 0);
    add(1, 4'hF, 4'h4, 4'h0, 0, 0, 0, 30'h0,  0, 0, 1, 2, 30'h40, 4'h0, 0);
    add(1, 4'hF, 4'h0, 4'h0, 0, 1, 2, 30'h44, 0, 0, 0, 0, 30'h0,  4'h4, 0);
    // memory op: ALU leg at N+1, LSU leg at N+5
    add(1, 4'hF, 4'h2, 4'h2, 0, 0, 0, 30'h0,  0, 0, 1, 1, 30'h0,  4'h0, 0);
    add(1, 4'hF, 4'h2, 4'h2, 0, 1, 1, 30'h10, 0, 0, 0, 0, 30'h0,  4'h2, 0);
    add(1, 4'hF, 4'h2, 4'h2, 0, 0, 0, 30'h0,  0, 0, 0, 0, 30'h0,  4'h2, 0);
    add(1, 4'hF, 4'h2, 4'h2, 0, 0, 0, 30'h0,  0, 0, 0, 0, 30'h0,  4'h2, 0);
    add(1, 4'hF, 4'h2, 4'h2, 0, 0, 0, 30'h0,  0, 0, 0, 0, 30'h0,  4'h2, 0);
    add(1, 4'hF, 4'h2, 4'h2, 0, 0, 0, 30'h0,  1, 1, 0, 0, 30'h0,  4'h2, 0);
    add(1, 4'hF, 4'h2, 4'h0, 0, 0, 0, 30'h0,  0, 0, 1, 1, 30'h10, 4'h0, 0);
    add(1, 4'hF, 4'h0, 4'h0, 0, 1, 1, 30'h14, 0, 0, 0, 0, 30'h0,  4'h2, 0);
    // memory op with ALU and LSU completing together
    add(1, 4'hF, 4'h8, 4'h8, 0, 0, 0, 30'h0,  0, 0, 1, 3, 30'h0,  4'h0, 0);
    add(1, 4'hF, 4'h0, 4'h0, 0, 1, 3, 30'h30, 1, 3, 0, 0, 30'h0,  4'h8, 0);
    add(1, 4'hF, 4'h8, 4'h0, 0, 0, 0, 30'h0,  0, 0, 1, 3, 30'h30, 4'h0, 0);
    add(1, 4'hF, 4'h0, 4'h0, 0, 1, 3, 30'h34, 0, 0, 0, 0, 30'h0,  4'h8, 0);
    // pointer to 3, then three stall cycles with 0 and 3 eligible
    add(1, 4'hF, 4'h4, 4'h0, 0, 0, 0, 30'h0,  0, 0, 1, 2, 30'h44, 4'h0, 0);
    add(1, 4'hF, 4'h9, 4'h0, 1, 1, 2, 30'h48, 0, 0, 0, 0, 30'h0,  4'h4, 0);
    add(1, 4'hF, 4'h9, 4'h0, 1, 0, 0, 30'h0,  0, 0, 0, 0, 30'h0,  4'h0, 0);
    add(1, 4'hF, 4'h9, 4'h0, 1, 0, 0, 30'h0,  0, 0, 0, 0, 30'h0,  4'h0, 0);
    add(1, 4'hF, 4'h9, 4'h0, 0, 0, 0, 30'h0,  0, 0, 1, 3, 30'h34, 4'h0, 0);
    add(1, 4'hF, 4'h9, 4'h0, 0, 1, 3, 30'h38, 0, 0, 1, 0, 30'h0,  4'h8, 0);
    add(1, 4'hF, 4'h0, 4'h0, 0, 1, 0, 30'h08, 0, 0, 0, 0, 30'h0,  4'h1, 0);
    // stray ALU completion for a READY thread: sticky err, PC kept
    add(1, 4'hF, 4'h0, 4'h0, 0, 1, 0, 30'h99, 0, 0, 0, 0, 30'h0,  4'h0, 0);
    add(1, 4'hF, 4'h1, 4'h0, 0, 0, 0, 30'h0,  0, 0, 1, 0, 30'h08, 4'h0, 1);
    add(1, 4'hF, 4'h0, 4'h0, 0, 1, 0, 30'h0C, 0, 0, 0, 0, 30'h0,  4'h1, 1);
    // thread_en[2] dropped while in flight
    add(1, 4'hF, 4'h4, 4'h0, 0, 0, 0, 30'h0,  0, 0, 1, 2, 30'h48, 4'h0, 1);
    add(1, 4'hB, 4'h4, 4'h0, 0, 0, 0, 30'h0,  0, 0, 0, 0, 30'h0,  4'h4, 1);
    add(1, 4'hB, 4'h4, 4'h0, 0, 1, 2, 30'h80, 0, 0, 0, 0, 30'h0,  4'h4, 1);
    add(1, 4'hB, 4'h4, 4'h0, 0, 0, 0, 30'h0,  0, 0, 0, 0, 30'h0,  4'h0, 1);
    add(1, 4'hB, 4'h4, 4'h0, 0, 0, 0, 30'h0,  0, 0, 0, 0, 30'h0,  4'h0, 1);
    add(1, 4'hF, 4'h4, 4'h0, 0, 0, 0, 30'h0,  0, 0, 0, 0, 30'h0,  4'h0, 1);
    add(1, 4'hF, 4'h4, 4'h0, 0, 0, 0, 30'h0,  0, 0, 1, 2, 30'h80, 4'h0, 1);
    add(1, 4'hF, 4'hB, 4'h0, 0, 0, 0, 30'h0,  0, 0, 1, 3, 30'h38, 4'h4, 1);

    for (int r = 0; r < vecs.size(); r++) begin
      @(posedge clk);
      #1;
      rst            = vecs[r].rst;
      thread_en      = vecs[r].en;
      inst_valid     = vecs[r].iv;
      inst_is_mem    = vecs[r].mem;
      alu_stall      = vecs[r].stall;
      alu_done_valid = vecs[r].ad_v;
      alu_done_tid   = vecs[r].ad_tid;
      alu_new_pc     = vecs[r].ad_pc;
      lsu_done_valid = vecs[r].ld_v;
      lsu_done_tid   = vecs[r].ld_tid;
      if (vecs[r].x_iv) expect_issue(vecs[r].x_tid, vecs[r].x_pc);
      @(negedge clk);
      observe($sformatf("row%0d", r), vecs[r].x_iv, vecs[r].x_tid, vecs[r].x_busy, vecs[r].x_err);
    end

    // Asynchronous reset between edges while thread 2 is in flight and 3 is issuing.
    #2 rst = 1'b0;
    #1 observe("midrst", 1'b0, 2'd0, 4'h0, 1'b0);

    // A completion left over from before reset must be flagged, and PCs are back at reset value.
    @(posedge clk);
    #1;
    rst = 1'b1; thread_en = 4'hF; inst_valid = 4'h0;
    alu_done_valid = 1'b1; alu_done_tid = 2'd2; alu_new_pc = 30'h77;
    @(negedge clk);
    observe("late0", 1'b0, 2'd0, 4'h0, 1'b0);

    @(posedge clk);
    #1;
    alu_done_valid = 1'b0; inst_valid = 4'h4;
    expect_issue(2'd2, RESET_PC);
    @(negedge clk);
    observe("late1", 1'b1, 2'd2, 4'h0, 1'b1);

    @(posedge clk);
    #1 inst_valid = 4'h0;
    @(negedge clk);
    observe("late2", 1'b0, 2'd0, 4'h4, 1'b1);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
